// File: rtl/alu_multiciclo.sv
// Handshaked RV32I-style ALU: single-cycle ops register their result at the
// accept edge; MUL runs as an XLEN-step shift-add sequence before delivering.
module alu_multiciclo #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 12,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  valor_reg1,
  input  logic [XLEN-1:0]  valor_reg2,
  input  logic [IMM_W-1:0] imediato,
  input  logic             ALUSrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  resultado_alu,
  output logic             resultado_desvio
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] result_q;
  logic            desvio_q;
  logic            out_valid_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [SHW-1:0]  cnt_q;

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] diff;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_d;
  logic            desvio_d;
  logic [XLEN-1:0] acc_step;
  logic            is_mul;
  logic            accept;
  logic            transfer;
  logic            mul_last;
  logic            mul_stall;

  assign imm_sext = {{(XLEN-IMM_W){imediato[IMM_W-1]}}, imediato};
  assign op_a     = valor_reg1;
  assign op_b     = ALUSrc ? imm_sext : valor_reg2;
  assign diff     = op_a - op_b;
  assign shamt    = op_b[SHW-1:0];
  assign is_mul   = MUL_EN && (op == 4'b1111);

  // The output slot is free when empty or being drained on this same edge.
  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready) && !reset;
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid_q && out_ready;

  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_last  = (cnt_q == CNT_LAST);
  assign mul_stall = mul_last && out_valid_q && !out_ready;

  always_comb begin
    alu_d    = '0;
    desvio_d = 1'b0;
    case (op)
      4'b0000: alu_d = op_a & op_b;
      4'b0001: alu_d = op_a | op_b;
      4'b0010: alu_d = op_a + op_b;
      4'b0011: alu_d = op_a ^ op_b;
      4'b0110: alu_d = diff;
      4'b0111: alu_d = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      4'b1000: alu_d = {{(XLEN-1){1'b0}}, op_a < op_b};
      4'b1001: alu_d = op_a << shamt;
      4'b1010: alu_d = op_a >> shamt;
      4'b1011: alu_d = $signed(op_a) >>> shamt;
      4'b1100: begin
        alu_d    = diff;
        desvio_d = (op_a == op_b);
      end
      4'b1101: begin
        alu_d    = diff;
        desvio_d = (op_a != op_b);
      end
      4'b1110: begin
        alu_d    = diff;
        desvio_d = $signed(op_a) < $signed(op_b);
      end
      default: begin
        alu_d    = '0;
        desvio_d = 1'b0;
      end
    endcase
  end

  // Control FSM; the multiplier's final step is held back rather than
  // overwrite a result the consumer has not yet taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      desvio_q    <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && is_mul) begin
            state_q     <= MUL;
            acc_q       <= '0;
            mcand_q     <= op_a;
            mplier_q    <= op_b;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            result_q    <= alu_d;
            desvio_q    <= desvio_d;
            out_valid_q <= 1'b1;
          end else if (transfer) begin
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          if (!mul_stall) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
            if (mul_last) begin
              result_q    <= acc_step;
              desvio_q    <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= IDLE;
            end else if (transfer) begin
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid        = out_valid_q;
  assign resultado_alu    = result_q;
  assign resultado_desvio = desvio_q;

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
Parametrised, handshaked successor to the core single-cycle ALU.
- Adds a valid/ready interface on input and output, a full RV32I-style operation set, and a signed-immediate operand path.
- Adds a multi-cycle shift-add multiplier controlled by an FSM.
- Sits between register-file read and writeback/branch logic. Results are registered and held until consumed.

Parameters:
XLEN, 32, datapath width in bits (power of 2, >= 8)
IMM_W, 12, immediate width; always sign-extended to XLEN
MUL_EN, 1, 1 = op 1111 is a multi-cycle multiply; 0 = op 1111 is treated as unused

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation request present
in_ready  out  1  block can accept a request this cycle
op  in  4  operation code
valor_reg1  in  XLEN  operand A
valor_reg2  in  XLEN  operand B (register)
imediato  in  IMM_W  immediate operand
ALUSrc  in  1  0 = B is valor_reg2; 1 = B is sext(imediato)
out_valid  out  1  result registers hold an unconsumed result
out_ready  in  1  consumer takes the result this cycle
resultado_alu  out  XLEN  registered result
resultado_desvio  out  1  registered branch-taken flag

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; resultado_alu = 0; resultado_desvio = 0; out_valid = 0; internal multiplier registers and counter = 0.
  - in_ready = 0 while reset is high.
  - Reset asserted mid-multiply aborts the operation; no result is produced.
- Operands: A = valor_reg1; B = ALUSrc ? sign-extend(imediato) : valor_reg2. All arithmetic is modulo 2^XLEN.
- Shift amount = B[log2(XLEN)-1:0].
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB.
  - 0111 SLT (signed) -> result 1 or 0.
  - 1000 SLTU (unsigned) -> result 1 or 0.
  - 1001 SLL, 1010 SRL, 1011 SRA.
  - 1100 BEQ, 1101 BNE, 1110 BLT (signed).
  - 1111 MUL: low XLEN bits of A*B.
  - 0100 and 0101 are unused: result 0, desvio 0, single-cycle.
- Branch ops: resultado_alu = A - B; resultado_desvio = 1 if the condition holds, else 0.
- All non-branch ops: resultado_desvio = 0. The flag is rewritten with every result, never left stale.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready) && !reset.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid = 1 and out_ready = 0, resultado_alu and resultado_desvio are held stable.
  - On a transfer with no new result loaded, out_valid falls at that edge.
- FSM states: IDLE, MUL.
  - IDLE, single-cycle op accepted: result registered and out_valid = 1 at the accept edge (latency 1). Throughput is 1 per cycle when out_ready is held at 1.
  - IDLE, MUL accepted (MUL_EN = 1): go to MUL; acc = 0, mcand = A, mplier = B, cnt = 0.
  - MUL, each edge: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
  - MUL, on the edge where cnt == XLEN-1: the final acc (including that step) is written to resultado_alu; desvio = 0; out_valid = 1; state -> IDLE. out_valid therefore rises XLEN edges after the accept edge.
  - MUL, output stall: if the final step is reached while out_valid && !out_ready (previous result not drained), the step and counter freeze until the slot frees. The result is never overwritten.
  - in_ready = 0 throughout MUL.
- in_valid without in_ready: the request is ignored. The requester must hold operands stable until accepted.

Test Plan:
- Reset then ADD: A = 5, ALUSrc = 1, imediato = 12'hFFF -> one cycle later out_valid = 1, resultado_alu = 4, desvio = 0. Also assert reset mid-result -> all outputs 0 immediately (asynchronous).
- Shifts and compares: SRA A = 32'h8000_0000, B = 4 -> 32'hF800_0000. SRL, same operands -> 32'h0800_0000. SLT A = -1, B = 1 -> 1. SLTU, same operands -> 0.
- Branches: BNE 3,3 -> desvio 0, result 0. BLT -1,1 -> desvio 1. BEQ 7,7 -> desvio 1. Then ADD issued next -> desvio returns to 0.
- Multiply: MUL 7*6 -> in_ready low for 32 cycles, out_valid rises exactly 32 edges after accept, result 42. MUL 32'hFFFF_FFFF * 2 -> 32'hFFFF_FFFE.
- Backpressure: out_ready = 0 for 5 cycles after an OR result -> result and out_valid held, in_ready = 0. Raise out_ready with a back-to-back XOR pending -> transfer and accept on the same edge, new result next cycle. Repeat with a MUL that finishes while stalled -> completes only after the drain.
- Reset mid-MUL at cycle 10 -> no out_valid pulse; after release, a fresh ADD completes normally.
